// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - binary score to multi-digit 7-segment controller
//
// Purpose: converts a binary score to DIGITS decimal digits with a sequential
// shift-add-3 converter, saturates values above 10^DIGITS-1, optionally blanks
// leading zeros and can blink the whole display.
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Rst_L     synchronous active-low reset
//   i_Score     binary score, sampled when i_Load=1
//   i_Load      conversion request (pulse or level)
//   i_Blink_En  1: display blinks, 0: steady
//   o_Busy      1 while a conversion is in progress
//   o_Valid     one-cycle pulse when o_Segments is updated
//   o_Overflow  1 when the displayed value was saturated
//   o_Segments  active-low {g,f,e,d,c,b,a} per digit, digit0 (units) in [6:0]
module score_display_ctrl #(
    parameter int SCORE_W   = 7,
    parameter int DIGITS    = 2,
    parameter int BLANK_LZ  = 1,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [SCORE_W-1:0]    i_Score,
    input  logic                  i_Load,
    input  logic                  i_Blink_En,
    output logic                  o_Busy,
    output logic                  o_Valid,
    output logic                  o_Overflow,
    output logic [7*DIGITS-1:0]   o_Segments
);

    localparam int BCD_W    = 4 * DIGITS;
    localparam int SR_W     = BCD_W + SCORE_W;
    localparam int MAX_SHOW = (10 ** DIGITS) - 1;
    localparam int CYC_W    = $clog2(SCORE_W + 1);
    localparam int CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // MAX_SHOW widened so the comparison works for any SCORE_W
    localparam logic [SCORE_W+31:0] MAX_W = (SCORE_W + 32)'(MAX_SHOW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_UPDATE
    } state_t;

    state_t                r_state;
    logic [SR_W-1:0]       r_sr;
    logic [CYC_W-1:0]      r_cnt;
    logic                  r_cur_ovf;
    logic                  r_pend;
    logic [SCORE_W-1:0]    r_pend_val;
    logic                  r_pend_ovf;
    logic [7*DIGITS-1:0]   r_seg;
    logic                  r_ovf;
    logic                  r_valid;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_blink_cnt;
    logic                  r_phase_on;

    logic                  w_cap_ovf;
    logic [SCORE_W-1:0]    w_cap_val;
    logic [SR_W-1:0]       w_add3;
    logic [SR_W-1:0]       w_sr_next;
    logic [7*DIGITS-1:0]   w_new_seg;
    logic [7*DIGITS-1:0]   w_rst_seg;
    logic [3:0]            w_digit;
    logic                  w_lead;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    // Saturate at capture time so the converter never sees a value that
    // would not fit in DIGITS decimal digits.
    always_comb begin
        w_cap_ovf = ({32'd0, i_Score} > MAX_W);
        w_cap_val = w_cap_ovf ? MAX_W[SCORE_W-1:0] : i_Score;
    end

    // One double-dabble step: correct every BCD nibble, then shift left.
    always_comb begin
        w_add3 = r_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_add3[SCORE_W+4*i +: 4] >= 4'd5) begin
                w_add3[SCORE_W+4*i +: 4] = w_add3[SCORE_W+4*i +: 4] + 4'd3;
            end
        end
        w_sr_next = {w_add3[SR_W-2:0], 1'b0};
    end

    // Decode the finished BCD field; blanking stops at the first
    // non-zero digit from the top, and digit0 is always shown.
    always_comb begin
        w_new_seg = '1;
        w_lead    = 1'b1;
        w_digit   = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_digit = r_sr[SCORE_W+4*i +: 4];
            if ((BLANK_LZ != 0) && w_lead && (w_digit == 4'd0) && (i != 0)) begin
                w_new_seg[7*i +: 7] = 7'b1111111;
            end else begin
                w_new_seg[7*i +: 7] = f_seg(w_digit);
                w_lead = 1'b0;
            end
        end
    end

    // Display image of value 0, used at reset.
    always_comb begin
        w_rst_seg = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i == 0) || (BLANK_LZ == 0)) begin
                w_rst_seg[7*i +: 7] = 7'b1000000;
            end else begin
                w_rst_seg[7*i +: 7] = 7'b1111111;
            end
        end
    end

    // o_Busy/o_Valid are registered from the state, so they trail it by one
    // edge; this lines the valid pulse up with the updated segments.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_cur_ovf  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_pend_ovf <= 1'b0;
            r_seg      <= w_rst_seg;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_busy  <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_Load) begin
                        r_sr      <= {{BCD_W{1'b0}}, w_cap_val};
                        r_cur_ovf <= w_cap_ovf;
                        r_cnt     <= '0;
                        r_state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_sr <= w_sr_next;
                    if (r_cnt == CYC_W'(SCORE_W - 1)) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (i_Load) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_cap_val;
                        r_pend_ovf <= w_cap_ovf;
                    end
                end
                S_UPDATE: begin
                    r_seg   <= w_new_seg;
                    r_ovf   <= r_cur_ovf;
                    r_valid <= 1'b1;
                    r_pend  <= 1'b0;
                    r_cnt   <= '0;
                    // A load arriving on this very edge is newer than the
                    // pending value, so it takes precedence.
                    if (i_Load) begin
                        r_sr      <= {{BCD_W{1'b0}}, w_cap_val};
                        r_cur_ovf <= w_cap_ovf;
                        r_state   <= S_CONVERT;
                    end else if (r_pend) begin
                        r_sr      <= {{BCD_W{1'b0}}, r_pend_val};
                        r_cur_ovf <= r_pend_ovf;
                        r_state   <= S_CONVERT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (!i_Blink_En) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Blink gates only the pins; the held segment image is untouched.
    assign o_Segments = r_phase_on ? r_seg : '1;
    assign o_Busy     = r_busy;
    assign o_Valid    = r_valid;
    assign o_Overflow = r_ovf;

endmodule
